// File: rtl/linear_combiner_n_if.sv
// Snapshot-in / result-out handshake bundle for linear_combiner_n.
// Channel 1 sits in the MSBs of x and w; each channel is packed {I,Q}.
interface linear_combiner_n_if #(
  parameter int N_CH = 8,
  parameter int W    = 18
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N_CH*2*W-1:0]   x;
  logic [N_CH*2*W-1:0]   w;
  logic                  conj_w;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*W-1:0]        y;
  logic                  sat;

  modport master (
    output in_valid, x, w, conj_w, out_ready,
    input  in_ready, out_valid, y, sat
  );

  modport slave (
    input  in_valid, x, w, conj_w, out_ready,
    output in_ready, out_valid, y, sat
  );
endinterface

// File: rtl/linear_combiner_n.sv
// Time-multiplexed complex linear combiner: y = sum_k w_k*x_k (or conj(w_k)*x_k),
// LANES complex MACs per cycle, half-up rounding and saturation to W-bit I/Q.
module linear_combiner_n #(
  parameter int N_CH  = 8,
  parameter int LANES = 2,
  parameter int W     = 18,
  parameter int FRAC  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  linear_combiner_n_if.slave bus
);

  localparam int G  = N_CH / LANES;
  localparam int IW = (G > 1) ? $clog2(G) : 1;
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW = 2*W + 2 + $clog2(N_CH);

  localparam logic signed [AW-1:0] ONE  = AW'(1);
  localparam logic signed [AW-1:0] HALF = ONE <<< (FRAC-1);
  localparam logic signed [AW-1:0] MAXV = (ONE <<< (W-1)) - ONE;
  localparam logic signed [AW-1:0] MINV = -(ONE <<< (W-1));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q;
  logic [N_CH*2*W-1:0]    x_q, w_q;
  logic                   conj_q;
  logic signed [AW-1:0]   acc_re_q, acc_im_q;
  logic signed [W-1:0]    y_re_q, y_im_q;
  logic                   sat_q;

  logic signed [W-1:0]    xi [N_CH];
  logic signed [W-1:0]    xq [N_CH];
  logic signed [W-1:0]    wi [N_CH];
  logic signed [W-1:0]    wq [N_CH];
  logic signed [AW-1:0]   part_re, part_im, sum_re, sum_im;
  logic [W:0]             rs_re, rs_im;
  logic [CW-1:0]          ch;
  logic                   in_rdy, accept, last;

  function automatic logic signed [AW-1:0] mul(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b);
    return AW'(p);
  endfunction

  // Returns {clamped, value}: half-up round, then clamp to the W-bit signed range.
  function automatic logic [W:0] round_sat(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] r;
    r = (v + HALF) >>> FRAC;
    if (r > MAXV)      return {1'b1, MAXV[W-1:0]};
    else if (r < MINV) return {1'b1, MINV[W-1:0]};
    else               return {1'b0, r[W-1:0]};
  endfunction

  for (genvar c = 0; c < N_CH; c++) begin : g_unpack
    assign xi[c] = x_q[(N_CH-c)*2*W-1   -: W];
    assign xq[c] = x_q[(N_CH-c)*2*W-W-1 -: W];
    assign wi[c] = w_q[(N_CH-c)*2*W-1   -: W];
    assign wq[c] = w_q[(N_CH-c)*2*W-W-1 -: W];
  end

  always_comb begin
    part_re = '0;
    part_im = '0;
    ch      = '0;
    for (int l = 0; l < LANES; l++) begin
      ch = CW'(int'(idx_q) * LANES + l);
      if (!conj_q) begin
        part_re = part_re + mul(wi[ch], xi[ch]) - mul(wq[ch], xq[ch]);
        part_im = part_im + mul(wi[ch], xq[ch]) + mul(wq[ch], xi[ch]);
      end else begin
        part_re = part_re + mul(wi[ch], xi[ch]) + mul(wq[ch], xq[ch]);
        part_im = part_im + mul(wi[ch], xq[ch]) - mul(wq[ch], xi[ch]);
      end
    end
    sum_re = acc_re_q + part_re;
    sum_im = acc_im_q + part_im;
    rs_re  = round_sat(sum_re);
    rs_im  = round_sat(sum_im);
  end

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    last    = (idx_q == IW'(G-1));
    case (state_q)
      IDLE:    in_rdy = 1'b1;
      OUT:     in_rdy = bus.out_ready;
      default: in_rdy = 1'b0;
    endcase
    accept = bus.in_valid && in_rdy;
    case (state_q)
      MAC:     if (last) state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = state_q;
    endcase
    if (accept) state_d = MAC;
  end

  // Snapshot capture, MAC accumulation and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      x_q      <= '0;
      w_q      <= '0;
      conj_q   <= 1'b0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      y_re_q   <= '0;
      y_im_q   <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q      <= bus.x;
        w_q      <= bus.w;
        conj_q   <= bus.conj_w;
        acc_re_q <= '0;
        acc_im_q <= '0;
        idx_q    <= '0;
      end else if (state_q == MAC) begin
        if (last) begin
          y_re_q <= rs_re[W-1:0];
          y_im_q <= rs_im[W-1:0];
          sat_q  <= rs_re[W] | rs_im[W];
        end else begin
          acc_re_q <= sum_re;
          acc_im_q <= sum_im;
          idx_q    <= idx_q + IW'(1);
        end
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == OUT);
  assign bus.y         = {y_re_q, y_im_q};
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_linear_combiner_n.sv
// Bench for linear_combiner_n: directed corner cases plus random snapshots,
// each compared against a plain-arithmetic complex dot-product model.
module tb_linear_combiner_n;
  localparam int N_CH = 8, LANES = 2, W = 18, FRAC = 16;
  localparam int G = N_CH / LANES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  linear_combiner_n_if #(.N_CH(N_CH), .W(W)) bus ();

  linear_combiner_n #(.N_CH(N_CH), .LANES(LANES), .W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int vectors = 0, miscompares = 0;
  int xi_a[N_CH], xq_a[N_CH], wi_a[N_CH], wq_a[N_CH];
  bit conj;
  longint e_i, e_q, e_s;

  task automatic check_val(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint y_re(); return longint'($signed(bus.y[2*W-1:W])); endfunction
  function automatic longint y_im(); return longint'($signed(bus.y[W-1:0])); endfunction

  function automatic longint rnd_sat(input longint v, output bit s);
    longint r, hi, lo;
    hi = (longint'(1) <<< (W-1)) - 1;
    lo = -(longint'(1) <<< (W-1));
    r  = (v + (longint'(1) <<< (FRAC-1))) >>> FRAC;
    s  = 1'b0;
    if (r > hi) begin r = hi; s = 1'b1; end
    if (r < lo) begin r = lo; s = 1'b1; end
    return r;
  endfunction

  task automatic model();
    longint si, sq, a, b, p, q;
    bit s1, s2;
    si = 0; sq = 0;
    for (int c = 0; c < N_CH; c++) begin
      a = wi_a[c]; b = wq_a[c]; p = xi_a[c]; q = xq_a[c];
      if (!conj) begin si += a*p - b*q; sq += a*q + b*p; end
      else       begin si += a*p + b*q; sq += a*q - b*p; end
    end
    e_i = rnd_sat(si, s1);
    e_q = rnd_sat(sq, s2);
    e_s = longint'(s1 | s2);
  endtask

  task automatic fill(input int xi, input int xq, input int wi, input int wq);
    for (int c = 0; c < N_CH; c++) begin
      xi_a[c] = xi; xq_a[c] = xq; wi_a[c] = wi; wq_a[c] = wq;
    end
  endtask

  task automatic fill_rand();
    for (int c = 0; c < N_CH; c++) begin
      xi_a[c] = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
      xq_a[c] = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
      wi_a[c] = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
      wq_a[c] = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
    end
    conj = 1'($urandom_range(0, 1));
  endtask

  task automatic drive();
    for (int c = 0; c < N_CH; c++) begin
      bus.x[(N_CH-c)*2*W-1   -: W] = W'(xi_a[c]);
      bus.x[(N_CH-c)*2*W-W-1 -: W] = W'(xq_a[c]);
      bus.w[(N_CH-c)*2*W-1   -: W] = W'(wi_a[c]);
      bus.w[(N_CH-c)*2*W-W-1 -: W] = W'(wq_a[c]);
    end
    bus.conj_w = conj;
  endtask

  task automatic scramble();
    for (int c = 0; c < 2*N_CH; c++) begin
      bus.x[c*W +: W] = W'($urandom);
      bus.w[c*W +: W] = W'($urandom);
    end
    bus.conj_w = ~bus.conj_w;
  endtask

  // Called #1 after the accept edge; counts that edge as edge 1.
  task automatic wait_out(input string tag);
    int n;
    n = 1;
    while (!bus.out_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check_val({tag, "_latency"}, n, G + 1);
  endtask

  task automatic check_y(input string tag, input longint ei, input longint eq, input longint es);
    check_val({tag, "_yI"}, y_re(), ei);
    check_val({tag, "_yQ"}, y_im(), eq);
    check_val({tag, "_sat"}, longint'(bus.sat), es);
  endtask

  task automatic run_txn(input string tag, input int stall);
    model();
    drive();
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    #1;
    check_val({tag, "_in_ready"}, longint'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble();
    wait_out(tag);
    check_y(tag, e_i, e_q, e_s);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check_val({tag, "_hold_valid"}, longint'(bus.out_valid), 1);
      check_val({tag, "_hold_in_ready"}, longint'(bus.in_ready), 0);
      check_y({tag, "_hold"}, e_i, e_q, e_s);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_val({tag, "_drained"}, longint'(bus.out_valid), 0);
  endtask

  task automatic backpressure_test();
    longint a_i, a_q, a_s, b_i, b_q, b_s;
    fill_rand();
    model(); a_i = e_i; a_q = e_q; a_s = e_s;
    drive();
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    #1;
    check_val("bp_in_ready_idle", longint'(bus.in_ready), 1);
    @(posedge clk); #1;
    fill_rand();
    model(); b_i = e_i; b_q = e_q; b_s = e_s;
    drive();
    wait_out("bp_a");
    for (int s = 0; s < 10; s++) begin
      check_y("bp_a_hold", a_i, a_q, a_s);
      check_val("bp_in_ready_stall", longint'(bus.in_ready), 0);
      check_val("bp_valid_stall", longint'(bus.out_valid), 1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    check_val("bp_in_ready_release", longint'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble();
    wait_out("bp_b");
    check_y("bp_b", b_i, b_q, b_s);
    @(posedge clk); #1;
    check_val("bp_b_drained", longint'(bus.out_valid), 0);
  endtask

  task automatic reset_test();
    fill_rand(); drive();
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_valid", longint'(bus.out_valid), 0);
    check_val("rst_mid_yI", y_re(), 0);
    check_val("rst_mid_yQ", y_im(), 0);
    check_val("rst_mid_sat", longint'(bus.sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_rel_in_ready", longint'(bus.in_ready), 1);
    fill_rand();
    run_txn("post_rst", 0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.conj_w = 1'b0;
    bus.x = '0; bus.w = '0;
    conj = 1'b0;
    #1;
    check_val("reset_valid", longint'(bus.out_valid), 0);
    check_val("reset_yI", y_re(), 0);
    check_val("reset_yQ", y_im(), 0);
    check_val("reset_sat", longint'(bus.sat), 0);
    check_val("reset_in_ready", longint'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    fill(1000, -500, 65536, 0); conj = 1'b0;
    run_txn("unity", 0);

    fill(0, 0, 0, 0); wi_a[0] = 0; wq_a[0] = 65536; xi_a[0] = 1000;
    conj = 1'b0; run_txn("jw_plain", 0);
    conj = 1'b1; run_txn("jw_conj", 0);

    fill(131071, 0, 65536, 0); conj = 1'b0; run_txn("sat_pos", 0);
    fill(-131072, 0, 65536, 0); run_txn("sat_neg", 0);
    fill(-131072, -131072, -131072, -131072); run_txn("extreme", 0);
    conj = 1'b1; run_txn("extreme_conj", 0);

    fill(0, 0, 0, 0); xi_a[0] = 3; xq_a[0] = -3; wi_a[0] = 32768; conj = 1'b0;
    run_txn("round", 0);

    backpressure_test();

    fill(1000, -500, 65536, 0); conj = 1'b0;
    run_txn("unity2", 0);
    reset_test();

    for (int t = 0; t < 40; t++) begin
      fill_rand();
      run_txn("rand", int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
